scan_sequencer: RTL
===================

Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 enable decoder: produces the 3-bit select and the enable that the decoder expands into one-hot channel strobes.
- Walks the 8 channels in ascending index order, skipping channels masked off.
- Holds each channel for a programmable dwell time, with a one-cycle break-before-make gap between channels.
- Runs a single pass or continuously; start/stop control with busy/done status.

Parameters:
DWELL_W, 8, width of the dwell-time input and internal dwell counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin scan; sampled only in IDLE
stop  input  1  abort scan; priority over start
mode  input  1  0 = single pass, 1 = continuous (wraps to lowest enabled channel)
mask  input  8  channel enable mask, bit i = channel i; captured at start
dwell  input  DWELL_W  enabled cycles per channel; captured at start; 0 treated as 1
sel  output  3  channel index to decoder select
en  output  1  decoder enable
busy  output  1  high in ACTIVE and GAP
done  output  1  one-cycle pulse at end of a single pass
wrap  output  1  one-cycle pulse each time continuous mode returns to the lowest channel

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). All outputs registered.
- Reset (rst_n=0 at a rising edge): state=IDLE, sel=0, en=0, busy=0, done=0, wrap=0, captured registers cleared. Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, ACTIVE, GAP.
- IDLE, start=1, stop=0, mask!=0:
  - Capture mask, dwell (0->1) and mode.
  - Next cycle: ACTIVE, sel=lowest set mask bit, en=1, busy=1, dwell counter=dwell_eff-1.
- IDLE, start=1, mask==0: ignored; stays IDLE with no outputs asserted.
- ACTIVE: counter decrements each cycle; en stays high exactly dwell_eff cycles. When counter==0:
  - Higher-index captured mask bit exists: go to GAP; en=0, sel held.
  - No higher bit, mode=1: go to GAP; wrap=1 during that GAP cycle.
  - No higher bit, mode=0: go to IDLE; en=0, busy=0, done=1 for one cycle, sel held.
- GAP: exactly one cycle with en=0, busy=1. Next cycle: ACTIVE, sel=next higher set bit (or lowest set bit after wrap), en=1, counter reloaded.
- Single enabled channel, continuous: ACTIVE(dwell_eff) / GAP(1) repeats on the same sel; wrap pulses every GAP.
- stop=1 in ACTIVE or GAP: next cycle IDLE, en=0, busy=0, no done, no wrap. stop in IDLE: no effect.
- start while busy: ignored. Changes to mask/dwell/mode while busy: no effect until the next start.
- Next-channel search: combinational priority search over the captured mask above the current sel, with no wrap inside a pass.
- sel never presents a masked-off channel while en=1.
- Dwell counter never underflows; maximum dwell = 2^DWELL_W-1 cycles.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-scan -> next cycle sel=0, en=0, busy=0, done=0, wrap=0; no done pulse.
- Single pass: mask=8'b0000_0101, dwell=3, mode=0, start pulse sampled at edge E0 ->
  - Cycles 1-3: sel=0, en=1.
  - Cycle 4: gap, en=0.
  - Cycles 5-7: sel=2, en=1.
  - Cycle 8: en=0, busy=0, done=1.
  - Cycle 9: done=0.
- Dwell 0 and full mask: mask=8'hFF, dwell=0, mode=0 -> sel 0..7 each en=1 for 1 cycle, separated by 1-cycle gaps; done=1 at cycle 16.
- Continuous wrap: mask=8'b1000_0010, dwell=2, mode=1 -> sel=1,1,gap,7,7,gap(wrap=1),1,1,... for 3 passes; done never asserts.
- Abort and priority: stop asserted during second ACTIVE cycle -> next cycle IDLE, en=0, busy=0, done=0. start=stop=1 in IDLE -> stays IDLE.
- Ignored inputs: start with mask=0 -> busy stays 0. start and mask changes while busy -> current scan unaffected and completes with the original mask.

Source files
------------

// File: rtl/scan_sequencer.sv
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Walks the enabled channels of a 3-to-8 decoder with a per-channel
//            dwell and a one-cycle break-before-make gap; single or continuous.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [7:0]         mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         sel,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   localparam int c_num_ch = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t             r_state, w_state_n;
   logic [2:0]         r_sel, w_sel_n;
   logic               r_en, w_en_n;
   logic               r_busy, w_busy_n;
   logic               r_done, w_done_n;
   logic               r_wrap, w_wrap_n;
   logic [DWELL_W-1:0] r_cnt, w_cnt_n;
   logic [DWELL_W-1:0] r_dwell_m1, w_dwell_m1_n;
   logic [7:0]         r_mask, w_mask_n;
   logic               r_mode, w_mode_n;

   logic               w_has_higher;
   logic [2:0]         w_next_higher;
   logic [DWELL_W-1:0] w_in_dwell_m1;

   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      lowest_bit = 3'd0;
      for (int i = c_num_ch - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = 3'(i);
      end
   endfunction

   // A dwell of zero behaves as one enabled cycle.
   assign w_in_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   always_comb begin
      w_has_higher  = 1'b0;
      w_next_higher = 3'd0;
      for (int i = c_num_ch - 1; i >= 0; i--) begin
         if (r_mask[i] && (3'(i) > r_sel)) begin
            w_has_higher  = 1'b1;
            w_next_higher = 3'(i);
         end
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_sel_n      = r_sel;
      w_en_n       = 1'b0;
      w_busy_n     = 1'b0;
      w_done_n     = 1'b0;
      w_wrap_n     = 1'b0;
      w_cnt_n      = r_cnt;
      w_dwell_m1_n = r_dwell_m1;
      w_mask_n     = r_mask;
      w_mode_n     = r_mode;

      case (r_state)
         ST_IDLE: begin
            if (start && !stop && (mask != 8'd0)) begin
               w_mask_n     = mask;
               w_mode_n     = mode;
               w_dwell_m1_n = w_in_dwell_m1;
               w_cnt_n      = w_in_dwell_m1;
               w_sel_n      = lowest_bit(mask);
               w_en_n       = 1'b1;
               w_busy_n     = 1'b1;
               w_state_n    = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (stop) begin
               w_state_n = ST_IDLE;
            end else if (r_cnt == '0) begin
               if (w_has_higher || r_mode) begin
                  w_state_n = ST_GAP;
                  w_busy_n  = 1'b1;
                  w_wrap_n  = !w_has_higher;
               end else begin
                  w_state_n = ST_IDLE;
                  w_done_n  = 1'b1;
               end
            end else begin
               w_cnt_n  = r_cnt - DWELL_W'(1);
               w_en_n   = 1'b1;
               w_busy_n = 1'b1;
            end
         end
         ST_GAP: begin
            if (stop) begin
               w_state_n = ST_IDLE;
            end else begin
               w_state_n = ST_ACTIVE;
               w_sel_n   = w_has_higher ? w_next_higher : lowest_bit(r_mask);
               w_cnt_n   = r_dwell_m1;
               w_en_n    = 1'b1;
               w_busy_n  = 1'b1;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sel      <= 3'd0;
         r_en       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
         r_cnt      <= '0;
         r_dwell_m1 <= '0;
         r_mask     <= 8'd0;
         r_mode     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_sel      <= w_sel_n;
         r_en       <= w_en_n;
         r_busy     <= w_busy_n;
         r_done     <= w_done_n;
         r_wrap     <= w_wrap_n;
         r_cnt      <= w_cnt_n;
         r_dwell_m1 <= w_dwell_m1_n;
         r_mask     <= w_mask_n;
         r_mode     <= w_mode_n;
      end
   end

   assign sel  = r_sel;
   assign en   = r_en;
   assign busy = r_busy;
   assign done = r_done;
   assign wrap = r_wrap;

endmodule

`default_nettype wire
